netlist_vector_driver: RTL and testbench

//  Sequential driving end of the 3-input B/C/D -> F gate netlist interface.

---
 rtl/netlist_pkg.sv | 26 ++
 rtl/netlist_vector_driver_if.sv | 30 +++
 rtl/netlist_vec_table.sv | 34 +++
 rtl/netlist_vector_driver.sv | 172 +++++++++++++++++
 tb/tb_netlist_vector_driver.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/netlist_pkg.sv
// Shared types for the B/C/D -> F netlist vector driver: FSM states, table entry
// layout and the golden reference function for F.
package netlist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Table entries carry hold counts up to this width; the HOLD_W parameter must not exceed it.
    localparam int HOLD_MAX_W = 16;

    typedef struct packed {
        logic                  b;
        logic                  c;
        logic                  d;
        logic [HOLD_MAX_W-1:0] hold;
    } vec_t;

    function automatic logic golden_f(input logic b, input logic c, input logic d);
        return ~(b & c & d);
    endfunction

endpackage

// File: rtl/netlist_vector_driver_if.sv
// Table-load and run-start bus of the netlist vector driver.
interface netlist_vector_driver_if #(
    parameter int IDX_W  = 2,
    parameter int HOLD_W = 8
);
    // Handshake: ld_valid and start have no ready of their own; the driver's busy output is the
    // inverse ready, and both are taken only in a cycle where busy is low, otherwise dropped.
    logic              ld_valid;
    logic [IDX_W-1:0]  ld_idx;
    logic [2:0]        ld_bcd;
    logic [HOLD_W-1:0] ld_hold;
    logic              start;

    modport master (
        output ld_valid,
        output ld_idx,
        output ld_bcd,
        output ld_hold,
        output start
    );

    modport slave (
        input ld_valid,
        input ld_idx,
        input ld_bcd,
        input ld_hold,
        input start
    );

endinterface

// File: rtl/netlist_vec_table.sv
// Register-file vector table: synchronous write port, combinational read by index.
module netlist_vec_table
    import netlist_pkg::*;
#(
    parameter int NUM_VEC = 4,
    parameter int IDX_W   = 2,
    parameter int HOLD_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [2:0]        wr_bcd,
    input  logic [HOLD_W-1:0] wr_hold,
    input  logic [IDX_W-1:0]  rd_idx,
    output vec_t              rd_vec
);

    vec_t tbl [NUM_VEC];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                tbl[i] <= '{b: 1'b0, c: 1'b0, d: 1'b0, hold: HOLD_MAX_W'(1)};
            end
        end else if (we && (int'(wr_idx) < NUM_VEC)) begin
            tbl[wr_idx] <= '{b: wr_bcd[2], c: wr_bcd[1], d: wr_bcd[0],
                             hold: HOLD_MAX_W'(wr_hold)};
        end
    end

    assign rd_vec = tbl[rd_idx];

endmodule

// File: rtl/netlist_vector_driver.sv
// Drives stored {B,C,D} vectors into the netlist and counts F mismatches against ~(B&C&D).
// Optional post-sample glitch counting on F is enabled by NETLIST_GLITCH_DET_EN.
module netlist_vector_driver
    import netlist_pkg::*;
#(
    parameter int  NUM_VEC = 4,
    parameter int  HOLD_W  = 8,
    parameter int  SETTLE  = 3,
    parameter int  CNT_W   = 8,
    localparam int IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    netlist_vector_driver_if.slave ld_bus,
    output logic                   vec_b,
    output logic                   vec_c,
    output logic                   vec_d,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [IDX_W-1:0]       cur_idx,
`ifdef NETLIST_GLITCH_DET_EN
    output logic [CNT_W-1:0]       glitch_cnt,
`endif
    output state_t                 state_dbg
);

    localparam int                   EL_W      = $clog2(SETTLE + 2);
    localparam logic [EL_W-1:0]      SAMPLE_AT = EL_W'(SETTLE);
    localparam logic [EL_W-1:0]      EL_MAX    = EL_W'(SETTLE + 1);
    localparam logic [HOLD_MAX_W-1:0] MIN_T    = HOLD_MAX_W'(SETTLE + 1);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_VEC - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [HOLD_MAX_W-1:0]   timer;
    logic [EL_W-1:0]         elapsed;
    logic                    f_q;
    logic                    tbl_we;
    logic                    sample_en;
    logic                    mismatch;
    logic                    glitch_ok;
    vec_t                    cur_vec;

    assign tbl_we = ld_bus.ld_valid && (state == IDLE);

    netlist_vec_table #(
        .NUM_VEC (NUM_VEC),
        .IDX_W   (IDX_W),
        .HOLD_W  (HOLD_W)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (tbl_we),
        .wr_idx  (ld_bus.ld_idx),
        .wr_bcd  (ld_bus.ld_bcd),
        .wr_hold (ld_bus.ld_hold),
        .rd_idx  (cur_idx),
        .rd_vec  (cur_vec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (ld_bus.start) state_nxt = APPLY;
            end
            APPLY: begin
                busy      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (timer == HOLD_MAX_W'(1)) begin
                    state_nxt = (cur_idx == LAST_IDX) ? DONE : APPLY;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign state_dbg = state;

    // The sample sees f_q, i.e. F as it stood one cycle earlier, SETTLE cycles after APPLY.
    assign sample_en = (state == WAIT) && (elapsed == SAMPLE_AT);
    assign mismatch  = f_q != golden_f(vec_b, vec_c, vec_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            elapsed <= '0;
            cur_idx <= '0;
            vec_b   <= 1'b0;
            vec_c   <= 1'b0;
            vec_d   <= 1'b0;
            f_q     <= 1'b0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            f_q <= f_in;
            case (state)
                IDLE: begin
                    if (ld_bus.start) begin
                        err_cnt <= '0;
                        pass    <= 1'b0;
                    end
                end
                APPLY: begin
                    vec_b   <= cur_vec.b;
                    vec_c   <= cur_vec.c;
                    vec_d   <= cur_vec.d;
                    timer   <= (cur_vec.hold > MIN_T) ? cur_vec.hold : MIN_T;
                    elapsed <= EL_W'(1);
                end
                WAIT: begin
                    timer <= timer - 1'b1;
                    if (elapsed != EL_MAX) elapsed <= elapsed + 1'b1;
                    if (sample_en && mismatch && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
                    if (timer == HOLD_MAX_W'(1)) begin
                        cur_idx <= (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
                    end
                end
                DONE: begin
                    pass <= (err_cnt == '0) && glitch_ok;
                end
                default: ;
            endcase
        end
    end

`ifdef NETLIST_GLITCH_DET_EN
    logic f_q_d;

    // Any f_q change after the sample point means F was not stable for the rest of the hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q_d      <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            f_q_d <= f_q;
            if ((state == IDLE) && ld_bus.start) begin
                glitch_cnt <= '0;
            end else if ((state == WAIT) && (elapsed > SAMPLE_AT) && (f_q != f_q_d)
                         && (glitch_cnt != '1)) begin
                glitch_cnt <= glitch_cnt + 1'b1;
            end
        end
    end

    assign glitch_ok = (glitch_cnt == '0);
`else
    assign glitch_ok = 1'b1;
`endif

endmodule

// File: tb/tb_netlist_vector_driver.sv
// Bench for netlist_vector_driver: cycle-timeline model of each run built from the vector table,
// per-cycle output comparison, plus literal checks on run length and counters.
module tb_netlist_vector_driver;
  import netlist_pkg::*;

  localparam int NUM_VEC = 4;
  localparam int HOLD_W  = 8;
  localparam int SETTLE  = 3;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  netlist_vector_driver_if #(.IDX_W(IDX_W), .HOLD_W(HOLD_W)) bus ();

  logic             vec_b, vec_c, vec_d, f_in;
  logic             busy, done, pass;
  logic [CNT_W-1:0] err_cnt;
  logic [IDX_W-1:0] cur_idx;
  state_t           state_dbg;
`ifdef NETLIST_GLITCH_DET_EN
  logic [CNT_W-1:0] glitch_cnt;
`endif

  // netlist model: correct NAND3, optionally stuck at 1 or with injected flips
  logic force_one = 1'b0;
  logic inj_cur   = 1'b0;
  assign f_in = force_one ? 1'b1 : (~(vec_b & vec_c & vec_d) ^ inj_cur);

  netlist_vector_driver #(
    .NUM_VEC (NUM_VEC),
    .HOLD_W  (HOLD_W),
    .SETTLE  (SETTLE),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_bus     (bus),
    .vec_b      (vec_b),
    .vec_c      (vec_c),
    .vec_d      (vec_d),
    .f_in       (f_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .cur_idx    (cur_idx),
`ifdef NETLIST_GLITCH_DET_EN
    .glitch_cnt (glitch_cnt),
`endif
    .state_dbg  (state_dbg)
  );

  int errors = 0;
  int checks = 0;

  // expected per-cycle observation {busy, done, cur_idx, b, c, d, err_cnt}
  logic [14:0] exp_q[$];
  logic [2:0]  m_bcd[NUM_VEC];
  int          m_hold[NUM_VEC];
  logic [2:0]  m_last;
  int          run_len;
  int          run_done_k;
  int          m_err;
`ifdef NETLIST_GLITCH_DET_EN
  int          m_glitch;
`endif
  logic        inj_arr[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // scoreboard: one comparison per cycle while a run timeline is pending
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [14:0] e;
      logic [14:0] g;
      e = exp_q.pop_front();
      g = {busy, done, cur_idx, vec_b, vec_c, vec_d, err_cnt};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle_chk t=%0t got busy=%b done=%b idx=%0d bcd=%b err=%0d, expected busy=%b done=%b idx=%0d bcd=%b err=%0d",
                 $time, g[14], g[13], g[12:11], g[10:8], g[7:0], e[14], e[13], e[12:11], e[10:8], e[7:0]);
      end
    end
  end

  // Timeline of a run from the table: vector i occupies 1 + max(hold,SETTLE+1) cycles, then one
  // done cycle; F seen at the sample of vector i is the netlist output SETTLE-1 cycles after APPLY.
  task automatic build_model(input bit force1);
    int         t_len[NUM_VEC];
    int         a_k[NUM_VEC];
    int         s_k[NUM_VEC];
    bit         mism[NUM_VEC];
    logic [2:0] bcd_at[$];
    int         idx_at[$];
    logic       fin[$];
    logic [2:0] cur;
    int         h;
    int         e_cnt;
    cur = m_last;
    for (int i = 0; i < NUM_VEC; i++) begin
      h = (m_hold[i] == 0) ? 1 : m_hold[i];
      t_len[i] = (h > SETTLE + 1) ? h : SETTLE + 1;
      a_k[i] = bcd_at.size();
      bcd_at.push_back(cur);
      idx_at.push_back(i);
      cur = m_bcd[i];
      for (int e = 1; e <= t_len[i]; e++) begin
        bcd_at.push_back(cur);
        idx_at.push_back(i);
      end
    end
    run_done_k = bcd_at.size();
    repeat (2) begin
      bcd_at.push_back(cur);
      idx_at.push_back(0);
    end
    run_len = bcd_at.size();
    while (inj_arr.size() < run_len) inj_arr.push_back(1'b0);
    for (int m = 0; m < run_len; m++) fin.push_back(force1 ? 1'b1 : ((~&bcd_at[m]) ^ inj_arr[m]));
    m_err = 0;
`ifdef NETLIST_GLITCH_DET_EN
    m_glitch = 0;
`endif
    for (int i = 0; i < NUM_VEC; i++) begin
      s_k[i] = a_k[i] + SETTLE;
      mism[i] = (fin[s_k[i] - 1] != (~&m_bcd[i]));
      if (mism[i]) m_err++;
`ifdef NETLIST_GLITCH_DET_EN
      for (int e = SETTLE + 1; e <= t_len[i]; e++) begin
        if (fin[a_k[i] + e - 1] != fin[a_k[i] + e - 2]) m_glitch++;
      end
`endif
    end
    for (int m = 0; m < run_len; m++) begin
      e_cnt = 0;
      for (int i = 0; i < NUM_VEC; i++) if (mism[i] && s_k[i] < m) e_cnt++;
      exp_q.push_back({(m <= run_done_k), (m == run_done_k), 2'(idx_at[m]), bcd_at[m], 8'(e_cnt)});
    end
    m_last = cur;
  endtask

  // driver tasks (entered and left at posedge + 1)
  task automatic load(input int idx, input logic [2:0] bcd, input int hold);
    bus.ld_valid = 1'b1;
    bus.ld_idx   = 2'(idx);
    bus.ld_bcd   = bcd;
    bus.ld_hold  = 8'(hold);
    @(posedge clk) #1;
    bus.ld_valid = 1'b0;
    m_bcd[idx]  = bcd;
    m_hold[idx] = hold;
  endtask

  task automatic run(input bit force1, input bit junk, input int abort_k, output int done_seen);
    bit aborted;
    bit pass_exp;
    aborted   = 1'b0;
    done_seen = -1;
    bus.start = 1'b1;
    force_one = force1;
    @(posedge clk) #1;
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    build_model(force1);
    inj_cur = inj_arr[0];
    for (int k = 0; k < run_len; k++) begin
      if (k == abort_k) begin
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (junk && k == 3) begin
        bus.start    = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_idx   = 2'd0;
        bus.ld_bcd   = ~m_bcd[0];
        bus.ld_hold  = 8'd9;
      end
      if (junk && k == run_done_k) bus.start = 1'b1;
      @(negedge clk);
      if (done && done_seen < 0) done_seen = k;
      @(posedge clk) #1;
      bus.start    = 1'b0;
      bus.ld_valid = 1'b0;
      inj_cur      = (k + 1 < run_len) ? inj_arr[k + 1] : 1'b0;
    end
    force_one = 1'b0;
    inj_cur   = 1'b0;
    inj_arr.delete();
    if (!aborted) begin
`ifdef NETLIST_GLITCH_DET_EN
      pass_exp = (m_err == 0) && (m_glitch == 0);
      check("glitch_cnt_run", 32'(glitch_cnt), 32'(m_glitch));
`else
      pass_exp = (m_err == 0);
`endif
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("done_cycle", 32'(done_seen), 32'(run_done_k));
      check("err_cnt_run", 32'(err_cnt), 32'(m_err));
      check("pass_run", 32'(pass), 32'(pass_exp));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_VEC; i++) begin
      m_bcd[i]  = 3'b000;
      m_hold[i] = 1;
    end
    m_last = 3'b000;
  endtask

  task automatic load_spec_table();
    load(0, 3'b111, 5);
    load(1, 3'b011, 8);
    load(2, 3'b010, 20);
    load(3, 3'b110, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ds;
    int done_seen_cnt;
    bus.ld_valid = 1'b0;
    bus.ld_idx   = '0;
    bus.ld_bcd   = '0;
    bus.ld_hold  = '0;
    bus.start    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_idx", 32'(cur_idx), 32'd0);
    check("rst_vec", 32'({vec_b, vec_c, vec_d}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk) #1;

    // reference table against a correct netlist: 6+9+21+5 cycles of vectors, done on cycle 41
    load_spec_table();
    run(1'b0, 1'b0, -1, ds);
    check("spec_done_at_41", 32'(ds), 32'd41);
    check("spec_err_0", 32'(err_cnt), 32'd0);
    check("spec_pass_1", 32'(pass), 32'd1);

    // F stuck at 1: only vector 0 (111) expects F=0
    run(1'b1, 1'b0, -1, ds);
    check("stuck1_err_1", 32'(err_cnt), 32'd1);
    check("stuck1_pass_0", 32'(pass), 32'd0);

    // hold=0 everywhere: 5 cycles per vector
    for (int i = 0; i < NUM_VEC; i++) load(i, 3'($urandom_range(0, 7)), 0);
    run(1'b0, 1'b0, -1, ds);
    check("hold0_done_at_20", 32'(ds), 32'd20);

    // start/ld while busy and start during done are ignored; next run proves the table unchanged
    load_spec_table();
    run(1'b0, 1'b1, -1, ds);
    check("busy_ign_idle", 32'(busy), 32'd0);
    run(1'b0, 1'b0, -1, ds);
    check("busy_ign_done_41", 32'(ds), 32'd41);

    // load and start in the same idle cycle: new entry 2 is used
    bus.ld_valid = 1'b1;
    bus.ld_idx   = 2'd2;
    bus.ld_bcd   = 3'b111;
    bus.ld_hold  = 8'd6;
    m_bcd[2]  = 3'b111;
    m_hold[2] = 6;
    run(1'b0, 1'b0, -1, ds);
    check("ld_start_done", 32'(ds), 32'd27);

    // randomized tables and netlist faults
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_VEC; i++) load(i, 3'($urandom_range(0, 7)), int'($urandom_range(0, 12)));
      for (int m = 0; m < 200; m++) inj_arr.push_back($urandom_range(0, 3) == 0);
      run(($urandom_range(0, 4) == 0), 1'b0, -1, ds);
    end

    // reset in WAIT of vector 2 (cycle 17 of the reference table)
    load_spec_table();
    run(1'b0, 1'b0, 17, ds);
    model_reset();
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_vec", 32'({vec_b, vec_c, vec_d}), 32'd0);
    check("abort_err", 32'(err_cnt), 32'd0);
    check("abort_idx", 32'(cur_idx), 32'd0);
    done_seen_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      if (done) done_seen_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(done_seen_cnt), 32'd0);
    @(posedge clk) #1;
    run(1'b0, 1'b0, -1, ds);
    check("abort_tbl_reset_done", 32'(ds), 32'd20);

`ifdef NETLIST_GLITCH_DET_EN
    // one-cycle flip in vector 1's window after its sample -> two f_q toggles
    load_spec_table();
    for (int m = 0; m < 60; m++) inj_arr.push_back(m == 10);
    run(1'b0, 1'b0, -1, ds);
    check("glitch_2", 32'(glitch_cnt), 32'd2);
    check("glitch_pass_0", 32'(pass), 32'd0);
    check("glitch_err_0", 32'(err_cnt), 32'd0);
    run(1'b0, 1'b0, -1, ds);
    check("glitch_const_0", 32'(glitch_cnt), 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
